// File: rtl/cla_sum_accumulator_pkg.sv
// Shared state encodings and sizing helper for the CLA sum accumulator.
package cla_sum_accumulator_pkg;

  // FSM state encodings
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  // Bits needed to hold values 0..value-1; never returns less than 1
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res++;
    end
    if (res == 0) begin
      res = 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/cla_sum_accumulator_adder.sv
// Combinational carry-lookahead adder; the result MSB is the carry out.
module cla_sum_accumulator_adder #(
  parameter int unsigned Width = 11
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width:0]   sum_o
);

  logic [Width-1:0] gen;
  logic [Width-1:0] prop;
  logic [Width:0]   carry;
  logic [Width-1:0] span;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  // Flat lookahead: carry into bit i+1 is any generate at j <= i whose
  // propagate chain j+1..i is fully set (no carry-in).
  always_comb begin
    carry = '0;
    span  = '0;
    for (int i = 0; i < int'(Width); i++) begin
      for (int j = 0; j <= i; j++) begin
        span = ({Width{1'b1}} >> (int'(Width) - 1 - i)) &
               ~({Width{1'b1}} >> (int'(Width) - 1 - j));
        carry[i+1] = carry[i+1] | (gen[j] & (&(prop | ~span)));
      end
    end
  end

  // Sum bits and carry out
  always_comb begin
    sum_o = {carry[Width], prop ^ carry[Width-1:0]};
  end

endmodule

// File: rtl/cla_sum_accumulator.sv
// Sums NUM_TERMS adder results per batch and offers the total on a
// valid/ready handshake, stalling the producer while the total waits.
module cla_sum_accumulator
  import cla_sum_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_TERMS = 4,
  parameter int unsigned ACC_WIDTH = 11
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_valid,
  input  logic [WIDTH:0]                     i_result,
  output logic                               o_ready,
  input  logic                               i_clear,
  output logic                               o_valid,
  output logic [ACC_WIDTH-1:0]               o_sum,
  output logic                               o_overflow,
  input  logic                               i_ready,
  output logic [clog2(NUM_TERMS+1)-1:0]      o_count
);

  localparam int unsigned CntW = clog2(NUM_TERMS + 1);

  logic [1:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic                 ovf_q, ovf_d;
  logic                 sum_ovf_q, sum_ovf_d;
  logic                 valid_q, valid_d;
  logic [CntW-1:0]      count_q, count_d;

  logic [ACC_WIDTH-1:0] term;
  logic [ACC_WIDTH:0]   add_res;
  logic [CntW-1:0]      count_inc;
  logic                 accept;
  logic                 last_term;

  assign term      = ACC_WIDTH'(i_result);
  assign o_ready   = (state_q != StDone);
  assign accept    = i_valid && o_ready;
  assign count_inc = count_q + CntW'(1);
  assign last_term = (count_inc == CntW'(NUM_TERMS));

  cla_sum_accumulator_adder #(
    .Width (ACC_WIDTH)
  ) u_adder (
    .a_i   (acc_q),
    .b_i   (term),
    .sum_o (add_res)
  );

  // Next-state: clear wins, otherwise advance the batch FSM
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    sum_ovf_d = sum_ovf_q;
    valid_d   = valid_q;
    count_d   = count_q;
    if (i_clear) begin
      state_d = StIdle;
      acc_d   = '0;
      count_d = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            acc_d   = term;
            count_d = CntW'(1);
            ovf_d   = 1'b0;
            if (NUM_TERMS == 1) begin
              sum_d     = term;
              sum_ovf_d = 1'b0;
              valid_d   = 1'b1;
              state_d   = StDone;
            end else begin
              state_d = StAccum;
            end
          end
        end
        StAccum: begin
          if (accept) begin
            acc_d   = add_res[ACC_WIDTH-1:0];
            ovf_d   = ovf_q | add_res[ACC_WIDTH];
            count_d = count_inc;
            if (last_term) begin
              sum_d     = add_res[ACC_WIDTH-1:0];
              sum_ovf_d = ovf_q | add_res[ACC_WIDTH];
              valid_d   = 1'b1;
              state_d   = StDone;
            end
          end
        end
        StDone: begin
          if (i_ready) begin
            valid_d = 1'b0;
            acc_d   = '0;
            count_d = '0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
      sum_ovf_q <= 1'b0;
      valid_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      ovf_q     <= ovf_d;
      sum_ovf_q <= sum_ovf_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_sum      = sum_q;
  assign o_overflow = sum_ovf_q;
  assign o_count    = count_q;

endmodule

// File: tb/tb_cla_sum_accumulator.sv
// Directed and random checks of cla_sum_accumulator at ACC_WIDTH 11 and 10.
module tb_cla_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid, i_clear, i_ready;
  logic [8:0] i_result;

  logic        ready_a, valid_a, ovf_a;
  logic [10:0] sum_a;
  logic [2:0]  count_a;
  logic        ready_b, valid_b, ovf_b;
  logic [9:0]  sum_b;
  logic [2:0]  count_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cla_sum_accumulator u_dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_result   (i_result),
    .o_ready    (ready_a),
    .i_clear    (i_clear),
    .o_valid    (valid_a),
    .o_sum      (sum_a),
    .o_overflow (ovf_a),
    .i_ready    (i_ready),
    .o_count    (count_a)
  );

  cla_sum_accumulator #(
    .WIDTH     (8),
    .NUM_TERMS (4),
    .ACC_WIDTH (10)
  ) u_dut_w10 (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_result   (i_result),
    .o_ready    (ready_b),
    .i_clear    (i_clear),
    .o_valid    (valid_b),
    .o_sum      (sum_b),
    .o_overflow (ovf_b),
    .i_ready    (i_ready),
    .o_count    (count_b)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then land on the next falling edge
  task automatic step(input logic iv, input int unsigned v, input logic ir, input logic clr);
    i_valid  = iv;
    i_result = 9'(v);
    i_ready  = ir;
    i_clear  = clr;
    @(negedge clk);
  endtask

  task automatic check_batch(input string tag, input int unsigned sa, input int unsigned oa,
                             input int unsigned sb, input int unsigned ob);
    check({tag, "_valid11"}, valid_a, 1);
    check({tag, "_valid10"}, valid_b, 1);
    check({tag, "_sum11"}, sum_a, sa);
    check({tag, "_ovf11"}, ovf_a, oa);
    check({tag, "_sum10"}, sum_b, sb);
    check({tag, "_ovf10"}, ovf_b, ob);
  endtask

  initial begin
    bit          m_done, m_ovf_a, m_ovf_b, iv, ir;
    int unsigned m_cnt, m_acc_a, m_acc_b, v, t, batches, cycles;

    rst = 1'b0;
    i_valid = 1'b0; i_result = '0; i_ready = 1'b0; i_clear = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_count", count_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_sum", sum_a, 0);
    check("rst_ovf", ovf_a, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", ready_a, 1);

    // Back-to-back batch, downstream always ready
    step(1, 17, 1, 0); step(1, 51, 1, 0); step(1, 28, 1, 0);
    check("b2b_not_early", valid_a, 0);
    step(1, 179, 1, 0);
    check_batch("b2b", 275, 0, 275, 0);
    check("b2b_ready_low", ready_a, 0);
    step(0, 0, 1, 0);
    check("b2b_valid_drop", valid_a, 0);
    check("b2b_ready_back", ready_a, 1);
    check("b2b_count0", count_a, 0);

    // Downstream stalls while producer keeps offering data
    step(1, 1, 0, 0); step(1, 2, 0, 0); step(1, 3, 0, 0); step(1, 4, 0, 0);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", valid_a, 1);
      check("stall_sum", sum_a, 10);
      check("stall_ready", ready_a, 0);
      check("stall_count", count_a, 4);
      step(1, 99, 0, 0);
    end
    step(0, 0, 1, 0);
    check("stall_taken", valid_a, 0);
    step(0, 0, 0, 0);
    check("stall_nothing_eaten", count_a, 0);

    // Wrap at 10 bits; input offered on the handoff cycle must be dropped
    step(1, 511, 1, 0); step(1, 511, 1, 0); step(1, 511, 1, 0); step(1, 511, 1, 0);
    check_batch("wrap", 2044, 0, 1020, 1);
    step(1, 1, 1, 0);
    check("handoff_count", count_a, 0);
    step(1, 1, 1, 0); step(1, 2, 1, 0); step(1, 3, 1, 0); step(1, 4, 1, 0);
    check_batch("after_wrap", 10, 0, 10, 0);
    step(0, 0, 1, 0);

    // Clear alongside third input drops it and restarts
    step(1, 10, 1, 0); step(1, 20, 1, 0); step(1, 30, 1, 1);
    check("clr_count", count_a, 0);
    check("clr_ready", ready_a, 1);
    check("clr_valid", valid_a, 0);
    step(1, 5, 1, 0); step(1, 5, 1, 0); step(1, 5, 1, 0); step(1, 5, 1, 0);
    check_batch("after_clr", 20, 0, 20, 0);
    step(0, 0, 1, 0);

    // Clear while a total is pending discards it
    step(1, 7, 0, 0); step(1, 7, 0, 0); step(1, 7, 0, 0); step(1, 7, 0, 0);
    check_batch("pend", 28, 0, 28, 0);
    step(1, 3, 0, 1);
    check("pend_clr_valid", valid_a, 0);
    check("pend_clr_count", count_a, 0);
    step(0, 0, 0, 0);
    check("pend_clr_idle", count_a, 0);

    // Asynchronous reset mid-batch
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    check("mid_count", count_a, 2);
    i_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_count", count_a, 0);
    check("arst_valid", valid_a, 0);
    check("arst_sum", sum_a, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 1, 1, 0); step(1, 1, 1, 0); step(1, 1, 1, 0); step(1, 1, 1, 0);
    check_batch("post_rst", 4, 0, 4, 0);
    step(0, 0, 1, 0);

    // Random gaps and stalls against a reference model
    m_done = 0; m_cnt = 0; m_acc_a = 0; m_acc_b = 0; m_ovf_a = 0; m_ovf_b = 0;
    batches = 0; cycles = 0;
    while (batches < 200 && cycles < 20000) begin
      cycles++;
      v  = $urandom_range(0, 511);
      iv = ($urandom_range(0, 9) < 7);
      ir = ($urandom_range(0, 1) == 1);
      check("rnd_ready", ready_a, m_done ? 0 : 1);
      check("rnd_valid11", valid_a, m_done);
      check("rnd_valid10", valid_b, m_done);
      check("rnd_count11", count_a, m_cnt);
      check("rnd_count10", count_b, m_cnt);
      if (m_done && ir) begin
        check("rnd_sum11", sum_a, m_acc_a);
        check("rnd_ovf11", ovf_a, m_ovf_a);
        check("rnd_sum10", sum_b, m_acc_b);
        check("rnd_ovf10", ovf_b, m_ovf_b);
      end
      if (m_done) begin
        if (ir) begin
          m_done = 0;
          m_cnt  = 0;
          batches++;
        end
      end else if (iv) begin
        if (m_cnt == 0) begin
          m_acc_a = v; m_acc_b = v; m_ovf_a = 0; m_ovf_b = 0;
        end else begin
          t = m_acc_a + v;
          if (t >= 2048) m_ovf_a = 1;
          m_acc_a = t % 2048;
          t = m_acc_b + v;
          if (t >= 1024) m_ovf_b = 1;
          m_acc_b = t % 1024;
        end
        m_cnt++;
        if (m_cnt == 4) m_done = 1;
      end
      step(iv, v, ir, 0);
    end
    check("rnd_batches", batches, 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
